byte_accumulate_sequencer: RTL and testbench
============================================

// Module: byte_accumulate_sequencer
// PURPOSE
//  Sequencer/accumulator placed around the 8-bit ripple adder. It takes a
//  stream of bytes, drives the adder's operand ports, and registers the adder's
//  sum/cout. It accumulates len bytes into a 16-bit total, then presents the
//  total downstream with a valid/ready handshake.
//  The adder carry-in is always driven to 0; carries are propagated by a
//  separate high-byte pass.
// PARAMETERS
//  LEN_W  4  width of len and the operand counter (1..16); max operands = 2**LEN_W-1
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      1-cycle request to begin accumulation; sampled only in IDLE
//  len       in   LEN_W  number of operands; sampled with start
//  in_valid  in   1      upstream byte valid
//  in_ready  out  1      block can accept a byte
//  in_data   in   8      operand byte
//  add_a     out  8      adder operand a
//  add_b     out  8      adder operand b
//  add_cin   out  1      adder carry-in; constant 0
//  add_sum   in   8      adder sum, combinational from add_a/add_b
//  add_cout  in   1      adder carry-out
//  out_valid out  1      result valid
//  out_ready in   1      downstream accepts result
//  out_data  out  16     accumulated total, modulo 2**16
//  out_ovf   out  1      sticky: total exceeded 16 bits
//  busy      out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; acc=0, carry=0, cnt=0, ovf=0; all outputs 0.
//   Reset mid-operation discards the operation entirely; no partial result is output.
//  FSM states: IDLE, WAIT_IN, ADD_LO, ADD_HI, DONE.
//  IDLE: in_ready=0, busy=0.
//   start=1, len!=0: acc<=0, ovf<=0, cnt<=len, go WAIT_IN.
//   start=1, len==0: acc<=0, ovf<=0, go DONE.
//  WAIT_IN: in_ready=1. On in_valid&&in_ready: op<=in_data, go ADD_LO.
//   Otherwise stay in WAIT_IN indefinitely.
//  ADD_LO: add_a=acc[7:0], add_b=op.
//   acc[7:0]<=add_sum, carry<=add_cout, go ADD_HI.
//  ADD_HI: add_a=acc[15:8], add_b={7'b0,carry}.
//   acc[15:8]<=add_sum; ovf<=ovf|add_cout; cnt<=cnt-1.
//   If cnt==1 go DONE, else go WAIT_IN.
//  DONE: out_valid=1; out_data=acc and out_ovf=ovf, held stable while out_valid=1.
//   On out_ready, go IDLE; out_valid drops the next cycle.
//  add_a/add_b: 0 outside ADD_LO/ADD_HI. add_cin: always 0.
//  Handshakes: a transfer occurs on valid&&ready at a rising edge.
//   in_ready is registered-state decoded; it does not depend on in_valid.
//   out_valid does not depend on out_ready.
//  start outside IDLE: ignored, including in DONE. start and out_ready both high in DONE:
//   the result is accepted, go IDLE, and that start is not honoured.
//  Latency: with in_valid held high, out_valid asserts 3*len+1 cycles after the start edge.
//   len==0 case: 1 cycle.
//  Throughput: one operand per 3 cycles, at most.
//  Width: the total wraps modulo 2**16, and ovf latches on any high-byte carry-out.
//   ovf is only reachable when LEN_W>=9.
// TESTING
//  T1 reset: hold rst_n=0 mid-ADD_HI -> IDLE immediately; all outputs 0; busy=0.
//  T2 sum: len=3, bytes 0x10,0x20,0x30, in_valid held 1 -> out_valid at cycle 10,
//     out_data=0x0060, ovf=0.
//  T3 carry: len=4, bytes 0xFF x4 -> out_data=0x03FC; a high-byte pass increments
//     on every low carry.
//  T4 backpressure/gaps: len=2, in_valid toggled with random gaps, out_ready held 0
//     for 5 cycles -> out_data=sum stable while waiting; 1 transfer on out_ready.
//  T5 boundaries: len=0 -> out_valid after 1 cycle with out_data=0. Start pulses during
//     busy -> ignored. len=15 of 0xFF -> 0x0EF1.
//  T6 overflow: LEN_W=9, len=258, bytes 0xFF -> out_data=0x00FE, out_ovf=1.
//     The next run with len=1, byte 0x01 -> ovf=0, out_data=0x0001.

Source files
------------

// File: rtl/byte_accumulate_sequencer.sv
// Byte accumulator wrapped around an external 8-bit adder.
// Low byte and carry pass are done in two separate adder cycles.
module byte_accumulate_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_cin,
    input  logic [7:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        ADD_LO,
        ADD_HI,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [15:0]      acc;
    logic [7:0]       op;
    logic             carry;
    logic             ovf;
    logic [LEN_W-1:0] cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? DONE : WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    state_nx = ADD_LO;
                end
            end
            ADD_LO: begin
                state_nx = ADD_HI;
            end
            ADD_HI: begin
                state_nx = (cnt == LEN_W'(1)) ? DONE : WAIT_IN;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulator halves, count and overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            op    <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        cnt <= len;
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        op <= in_data;
                    end
                end
                ADD_LO: begin
                    acc[7:0] <= add_sum;
                    carry    <= add_cout;
                end
                ADD_HI: begin
                    acc[15:8] <= add_sum;
                    ovf       <= ovf | add_cout;
                    cnt       <= cnt - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_ovf   = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            WAIT_IN: begin
                in_ready = 1'b1;
            end
            ADD_LO: begin
                add_a = acc[7:0];
                add_b = op;
            end
            ADD_HI: begin
                add_a = acc[15:8];
                add_b = {7'b0, carry};
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                out_ovf   = ovf;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_byte_accumulate_sequencer.sv
// Bench for byte_accumulate_sequencer: behavioural adder,
// vector table for LEN_W=4 and a LEN_W=9 instance for overflow.
module tb_byte_accumulate_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        busy;

    logic        s9;
    logic [8:0]  len9;
    logic        iv9;
    logic        ir9;
    logic [7:0]  id9;
    logic [7:0]  a9;
    logic [7:0]  b9;
    logic        cin9;
    logic [7:0]  sum9;
    logic        cout9;
    logic        ov9;
    logic        or9;
    logic [15:0] od9;
    logic        ovf9;
    logic        busy9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);
    assign {cout9, sum9} = 9'(a9) + 9'(b9) + 9'(cin9);

    byte_accumulate_sequencer #(.LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
    );

    byte_accumulate_sequencer #(.LEN_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(s9), .len(len9),
        .in_valid(iv9), .in_ready(ir9), .in_data(id9),
        .add_a(a9), .add_b(b9), .add_cin(cin9),
        .add_sum(sum9), .add_cout(cout9),
        .out_valid(ov9), .out_ready(or9),
        .out_data(od9), .out_ovf(ovf9), .busy(busy9)
    );

    typedef struct {
        int          n;
        logic [7:0]  base;
        logic [7:0]  step;
        bit          gaps;
        bit          poke;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run4(input vec_t v, input int k);
        int          idx;
        int          cyc;
        logic [15:0] hold;
        logic        hovf;
        bit          ok;
        idx = 0;
        cyc = 0;
        start = 1'b1;
        len = 4'(v.n);
        in_valid = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (v.poke && cyc == 5) begin
                start = 1'b1;
                len = 4'd0;
            end
            if (out_valid || cyc > 300) break;
            in_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = in_valid ? v.base + 8'(idx) * v.step : 8'($urandom);
            if (in_valid && in_ready) idx++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (cyc > 300) begin
            chk($sformatf("v%0d_timeout", k), cyc, 0);
            return;
        end
        chk($sformatf("v%0d_data", k), out_data, v.exp);
        chk($sformatf("v%0d_ovf", k), out_ovf, 0);
        chk($sformatf("v%0d_taken", k), idx, v.n);
        if (v.lat >= 0) chk($sformatf("v%0d_lat", k), cyc, v.lat);
        hold = out_data;
        hovf = out_ovf;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || out_data != hold || out_ovf != hovf
                || in_ready || !busy || add_a != 0 || add_b != 0
                || add_cin)
                ok = 1'b0;
        end
        chk($sformatf("v%0d_hold", k), ok, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d_drop", k), {out_valid, busy, out_data}, 0);
    endtask

    task automatic run9(input int n, input logic [7:0] b,
                        input logic [15:0] exp, input logic eovf,
                        input string tag);
        int cyc;
        cyc = 0;
        s9 = 1'b1;
        len9 = 9'(n);
        iv9 = 1'b0;
        id9 = b;
        while (1) begin
            @(negedge clk);
            cyc++;
            s9 = 1'b0;
            iv9 = 1'b1;
            if (ov9 || cyc > 1000) break;
        end
        iv9 = 1'b0;
        chk({tag, "_lat"}, cyc, 3 * n + 1);
        chk({tag, "_data"}, od9, exp);
        chk({tag, "_ovf"}, ovf9, eovf);
        or9 = 1'b1;
        @(negedge clk);
        or9 = 1'b0;
        chk({tag, "_drop"}, {ov9, busy9}, 0);
    endtask

    initial begin
        vecs[0] = '{3,  8'h10, 8'h10, 0, 0, 16'h0060, 10};
        vecs[1] = '{4,  8'hFF, 8'h00, 0, 0, 16'h03FC, 13};
        vecs[2] = '{2,  8'h3C, 8'h11, 1, 0, 16'h0089, -1};
        vecs[3] = '{0,  8'h00, 8'h00, 0, 0, 16'h0000, 1};
        vecs[4] = '{15, 8'hFF, 8'h00, 0, 1, 16'h0EF1, 46};
        vecs[5] = '{5,  8'h80, 8'h01, 0, 0, 16'h028A, 16};
        vecs[6] = '{2,  8'hF0, 8'h20, 0, 0, 16'h0100, 7};
        vecs[7] = '{1,  8'h01, 8'h00, 1, 0, 16'h0001, -1};

        rst_n = 1'b0;
        start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0;
        s9 = 1'b0; len9 = '0; iv9 = 1'b0; id9 = '0; or9 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            {busy, in_ready, out_valid, out_ovf, out_data,
             add_a, add_b, add_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run4(vecs[i], i);
            @(negedge clk);
        end

        // Reset in the middle of a high-byte pass
        start = 1'b1; len = 4'd3; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {busy, in_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs",
            {busy, in_ready, out_valid, out_ovf, out_data,
             add_a, add_b, add_cin}, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {busy, out_valid}, 0);
        run4(vecs[0], 10);

        // start with out_ready in DONE: accepted, start not honoured
        @(negedge clk);
        start = 1'b1; len = 4'd0;
        @(negedge clk);
        chk("z_valid", out_valid, 1);
        start = 1'b1; len = 4'd2; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk("z_accept", {out_valid, busy}, 0);
        repeat (2) @(negedge clk);
        chk("z_no_restart", {busy, in_ready}, 0);

        // Overflow on the wide instance, then cleared by next run
        run9(258, 8'hFF, 16'h00FE, 1'b1, "ovf_run");
        @(negedge clk);
        run9(1, 8'h01, 16'h0001, 1'b0, "ovf_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
